seg7_scan: RTL

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 97 +++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver: latches a 16-bit hex value and blank mask on load,
// then scans the digits with active-low anode and segment drive, pulsing frame once per full scan.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  dsp_7seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      hold_v_q, hold_v_d;
  logic [3:0]       hold_b_q, hold_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       dsp_q, dsp_d;
  logic             wrap_q, wrap_d;
  logic             frame_q, frame_d;
  logic             terminal;
  logic [3:0]       digit;

  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    hold_v_d = load ? value : hold_v_q;
    hold_b_d = load ? blank : hold_b_q;

    terminal = (cnt_q == CNT_LAST);
    cnt_d    = terminal ? '0 : cnt_q + 1'b1;
    idx_d    = terminal ? idx_q + 2'd1 : idx_q;

    // Outputs track the pre-edge index and holding registers, so they lag idx by one cycle.
    digit = hold_v_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << idx_q);
    dsp_d = hold_b_q[idx_q] ? 7'b1111111 : hex_decode(digit);

    // frame trails the 3->0 wrap by one edge, lining up with an returning to digit 0.
    wrap_d  = terminal && (idx_q == 2'd3);
    frame_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= '0;
      hold_b_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1111;
      dsp_q    <= 7'b1111111;
      wrap_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_b_q <= hold_b_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      dsp_q    <= dsp_d;
      wrap_q   <= wrap_d;
      frame_q  <= frame_d;
    end
  end

  assign an       = an_q;
  assign dsp_7seg = dsp_q;
  assign frame    = frame_q;

endmodule
